data_mem_responder: RTL

- Responder (memory-side) end of the CPU load/store data interface.
- Accepts one request at a time from the pipeline's memory stage over a valid/ready request channel.
- Models configurable wait states, executes byte, halfword or word reads and writes on an internal little-endian word array.
- Returns one response per request over a valid/ready response channel.

---
 rtl/data_mem_responder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Memory-side responder for the CPU load/store data port, with wait states.
// Optional DMEM_ERR_CHECK_EN adds misalignment and out-of-range error reporting.
module data_mem_responder #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_LOG2    = 10,
    parameter int WAIT_STATES   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic                     rsp_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                   state;
    logic [CW-1:0]            cnt;
    logic                     we_q;
    logic [1:0]               size_q;
    logic                     uns_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];

    logic                     accept;
    logic                     enter_resp;
    logic                     cur_we;
    logic [1:0]               cur_size;
    logic                     cur_uns;
    logic [ADDRESS_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0]    cur_wdata;
    logic [DEPTH_LOG2-1:0]    idx;
    logic [1:0]               lane;
    logic [1:0]               eff_lane;
    logic                     is_word;
    logic                     is_half;
    logic                     err;
    logic [3:0]               be;
    logic [DATA_WIDTH-1:0]    wd;
    logic [DATA_WIDTH-1:0]    shifted;
    logic [DATA_WIDTH-1:0]    rdata_next;

    assign accept     = (state == IDLE) && req_valid && req_ready;
    assign enter_resp = (WAIT_STATES == 0) ? accept
                                           : ((state == WAIT) && (cnt == '0));

    // The zero-wait path commits on the accept edge, so use live inputs in IDLE.
    assign cur_we    = (state == IDLE) ? req_we       : we_q;
    assign cur_size  = (state == IDLE) ? req_size     : size_q;
    assign cur_uns   = (state == IDLE) ? req_unsigned : uns_q;
    assign cur_addr  = (state == IDLE) ? req_addr     : addr_q;
    assign cur_wdata = (state == IDLE) ? req_wdata    : wdata_q;

    assign idx     = cur_addr[DEPTH_LOG2+1:2];
    assign lane    = cur_addr[1:0];
    assign is_word = cur_size[1];
    assign is_half = (cur_size == 2'b01);

`ifdef DMEM_ERR_CHECK_EN
    assign err = (is_half && lane[0]) || (is_word && (lane != 2'b00))
              || (|cur_addr[ADDRESS_WIDTH-1:DEPTH_LOG2+2]);
`else
    logic unused_upper;
    assign unused_upper = ^cur_addr[ADDRESS_WIDTH-1:DEPTH_LOG2+2];
    assign err = 1'b0;
`endif

    always_comb begin
        eff_lane = lane;
        be       = 4'b0001 << lane;
        wd       = {4{cur_wdata[7:0]}};
        unique case (1'b1)
            is_word: begin
                eff_lane = 2'b00;
                be       = 4'b1111;
                wd       = cur_wdata;
            end
            is_half: begin
                eff_lane = {lane[1], 1'b0};
                be       = 4'b0011 << {lane[1], 1'b0};
                wd       = {2{cur_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted    = mem[idx] >> {eff_lane, 3'b000};
        rdata_next = '0;
        if (!cur_we && !err) begin
            unique case (1'b1)
                is_word: rdata_next = shifted;
                is_half: rdata_next = {{16{!cur_uns && shifted[15]}}, shifted[15:0]};
                default: rdata_next = {{24{!cur_uns && shifted[7]}}, shifted[7:0]};
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            size_q    <= 2'b00;
            uns_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rdata_next;
                            rsp_err   <= err;
                        end else begin
                            state <= WAIT;
                            cnt   <= CW'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_next;
                        rsp_err   <= err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
